// File: rtl/id_access_sequencer_pkg.sv
// rtl/id_access_sequencer_pkg.sv - shared encodings for the identity check sequencer
package id_access_sequencer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_COMPARE = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;
    localparam logic [2:0] ST_LOCK    = 3'd6;

    localparam logic [1:0] RC_GRANT    = 2'b00;
    localparam logic [1:0] RC_MISMATCH = 2'b01;
    localparam logic [1:0] RC_BAD_ID   = 2'b10;

    localparam logic [3:0] BAD_SLOT = 4'hF;

    localparam logic [2:0] ID_SLOT0 = 3'b001;
    localparam logic [2:0] ID_SLOT1 = 3'b010;
    localparam logic [2:0] ID_SLOT2 = 3'b011;
    localparam logic [2:0] ID_SLOT3 = 3'b101;
    localparam logic [2:0] ID_SLOT4 = 3'b110;

endpackage

// File: rtl/id_access_sequencer_if.sv
// rtl/id_access_sequencer_if.sv - request, record-memory and response signals of the sequencer
interface id_access_sequencer_if #(
    parameter int KEY_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_id;
    logic [KEY_W-1:0] req_key;
    logic [3:0]       mem_addr;
    logic             mem_rd_en;
    logic [KEY_W-1:0] mem_rd_data;
    logic             resp_valid;
    logic             resp_grant;
    logic [1:0]       resp_code;
    logic [3:0]       resp_slot;
    logic             locked;

    modport slave (
        input  req_valid, req_id, req_key, mem_rd_data,
        output req_ready, mem_addr, mem_rd_en, resp_valid, resp_grant, resp_code, resp_slot, locked
    );

    modport master (
        output req_valid, req_id, req_key, mem_rd_data,
        input  req_ready, mem_addr, mem_rd_en, resp_valid, resp_grant, resp_code, resp_slot, locked
    );
endinterface

// File: rtl/id_slot_decode.sv
// rtl/id_slot_decode.sv - 3-bit user id to record-memory slot, also used by front-end display
module id_slot_decode
    import id_access_sequencer_pkg::*;
(
    input  logic [2:0] id,
    output logic       valid,
    output logic [3:0] slot
);
    always_comb begin
        valid = 1'b1;
        slot  = BAD_SLOT;
        case (id)
            ID_SLOT0: slot = 4'd0;
            ID_SLOT1: slot = 4'd1;
            ID_SLOT2: slot = 4'd2;
            ID_SLOT3: slot = 4'd3;
            ID_SLOT4: slot = 4'd4;
            default:  valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_access_sequencer.sv
// rtl/id_access_sequencer.sv - one key check per request with consecutive-failure lockout
module id_access_sequencer
    import id_access_sequencer_pkg::*;
#(
    parameter int KEY_W       = 8,
    parameter int RD_LAT      = 1,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_access_sequencer_if.slave bus
);
    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int WW = $clog2(RD_LAT + 1);

    logic [2:0]       state;
    logic [2:0]       id_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] stored_q;
    logic [FW-1:0]    fail_cnt;
    logic [TW-1:0]    lock_tmr;
    logic [WW-1:0]    wait_cnt;
    logic [3:0]       addr_q;
    logic             grant_q;
    logic [1:0]       code_q;
    logic [3:0]       slot_q;
    logic             dec_valid;
    logic [3:0]       dec_slot;

    id_slot_decode u_decode (
        .id    (id_q),
        .valid (dec_valid),
        .slot  (dec_slot)
    );

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.mem_rd_en  = (state == ST_READ);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.locked     = (state == ST_LOCK);
    assign bus.mem_addr   = addr_q;
    assign bus.resp_grant = grant_q;
    assign bus.resp_code  = code_q;
    assign bus.resp_slot  = slot_q;

    // Response fields are written on the edge entering RESP so they only change with resp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            id_q     <= '0;
            key_q    <= '0;
            stored_q <= '0;
            fail_cnt <= '0;
            lock_tmr <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
            grant_q  <= 1'b0;
            code_q   <= RC_GRANT;
            slot_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        id_q  <= bus.req_id;
                        key_q <= bus.req_key;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!dec_valid) begin
                        grant_q <= 1'b0;
                        code_q  <= RC_BAD_ID;
                        slot_q  <= BAD_SLOT;
                        state   <= ST_RESP;
                    end else begin
                        addr_q <= dec_slot;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WW'(RD_LAT - 1)) begin
                        stored_q <= bus.mem_rd_data;
                        state    <= ST_COMPARE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ST_COMPARE: begin
                    slot_q <= addr_q;
                    if (stored_q == key_q) begin
                        grant_q  <= 1'b1;
                        code_q   <= RC_GRANT;
                        fail_cnt <= '0;
                    end else begin
                        grant_q <= 1'b0;
                        code_q  <= RC_MISMATCH;
                        if (fail_cnt != FW'(MAX_FAIL))
                            fail_cnt <= fail_cnt + FW'(1);
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= (fail_cnt == FW'(MAX_FAIL)) ? ST_LOCK : ST_IDLE;
                end
                ST_LOCK: begin
                    if (lock_tmr == TW'(LOCK_CYCLES - 1)) begin
                        lock_tmr <= '0;
                        fail_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        lock_tmr <= lock_tmr + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_id_access_sequencer.sv
// tb/tb_id_access_sequencer.sv - scoreboard bench for id_access_sequencer at RD_LAT 1 and 3
module tb_id_access_sequencer;
    import id_access_sequencer_pkg::*;

    typedef struct {
        logic       grant;
        logic [1:0] code;
        logic [3:0] slot;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    logic [7:0] mem [16];
    int         rca = 15;
    int         rcb = 15;
    logic [3:0] raa = '0;
    logic [3:0] rab = '0;

    id_access_sequencer_if #(.KEY_W(8)) ifa ();
    id_access_sequencer_if #(.KEY_W(8)) ifb ();

    id_access_sequencer #(.KEY_W(8), .RD_LAT(1), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    id_access_sequencer #(.KEY_W(8), .RD_LAT(3), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: correct data only exactly RD_LAT cycles after the strobe, inverted otherwise.
    always @(negedge clk) begin
        if (ifa.mem_rd_en) begin rca <= 0; raa <= ifa.mem_addr; end
        else if (rca < 15) rca <= rca + 1;
        if (ifb.mem_rd_en) begin rcb <= 0; rab <= ifb.mem_addr; end
        else if (rcb < 15) rcb <= rcb + 1;
    end
    assign ifa.mem_rd_data = (rca == 1) ? mem[raa] : ~mem[raa];
    assign ifb.mem_rd_data = (rcb == 3) ? mem[rab] : ~mem[rab];

    task automatic do_req(input logic [2:0] id, input logic [7:0] key,
                          input logic g, input logic [1:0] code, input logic [3:0] slot);
        exp_t e;
        int   c0;
        int   rd_at;
        bit   got;
        bit   busy_bad;
        @(negedge clk);
        total++;
        if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b exp=1", ifa.req_ready); end
        ifa.req_valid = 1'b1; ifa.req_id = id; ifa.req_key = key;
        c0 = cyc;
        e.grant = g; e.code = code; e.slot = slot;
        e.cyc = c0 + ((code == RC_BAD_ID) ? 2 : 5);
        sb.push_back(e);
        rd_at = -1; got = 0; busy_bad = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            ifa.req_valid = ($urandom_range(0, 1) == 1);
            ifa.req_id = 3'($urandom); ifa.req_key = 8'($urandom);
            if (ifa.req_ready !== 1'b0) busy_bad = 1;
            if (ifa.mem_rd_en === 1'b1) begin
                rd_at = cyc - c0;
                total++;
                if (ifa.mem_addr !== slot) begin bad++; $display("FAIL mem_addr got=%0h exp=%0h", ifa.mem_addr, slot); end
            end
            if (ifa.resp_valid === 1'b1) begin
                got = 1;
                e = sb.pop_front();
                total++;
                if ({ifa.resp_grant, ifa.resp_code, ifa.resp_slot} !== {e.grant, e.code, e.slot}) begin
                    bad++;
                    $display("FAIL resp_fields got=%b/%b/%h exp=%b/%b/%h", ifa.resp_grant, ifa.resp_code,
                             ifa.resp_slot, e.grant, e.code, e.slot);
                end
                total++;
                if (cyc !== e.cyc) begin bad++; $display("FAIL resp_latency got=%0d exp=%0d", cyc - c0, e.cyc - c0); end
            end
        end
        ifa.req_valid = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL resp_timeout got=none exp=resp"); void'(sb.pop_front()); end
        total++;
        if (busy_bad) begin bad++; $display("FAIL req_ready_busy got=1 exp=0"); end
        total++;
        if (rd_at !== ((code == RC_BAD_ID) ? -1 : 2)) begin bad++; $display("FAIL rd_en_cycle got=%0d exp=%0d", rd_at, (code == RC_BAD_ID) ? -1 : 2); end
    endtask

    // Counts locked cycles while hammering the request port; reports any response or ready seen.
    task automatic drain_lock(output int n, output bit spur);
        n = 0; spur = 0;
        while (ifa.locked === 1'b1 && n < 200) begin
            n++;
            if (ifa.resp_valid !== 1'b0 || ifa.req_ready !== 1'b0) spur = 1;
            ifa.req_valid = 1'b1; ifa.req_id = ID_SLOT1; ifa.req_key = 8'h5A;
            @(negedge clk);
        end
        ifa.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({ifa.req_ready, ifa.mem_rd_en, ifa.resp_valid, ifa.resp_grant, ifa.locked} !== 5'b10000) begin
            bad++; $display("FAIL reset_flags got=%b exp=10000",
                {ifa.req_ready, ifa.mem_rd_en, ifa.resp_valid, ifa.resp_grant, ifa.locked});
        end
        total++;
        if ({ifa.mem_addr, ifa.resp_code, ifa.resp_slot} !== 10'd0) begin
            bad++; $display("FAIL reset_fields got=%h/%b/%h exp=0/00/0", ifa.mem_addr, ifa.resp_code, ifa.resp_slot);
        end
        total++;
        if ({ifb.req_ready, ifb.mem_rd_en, ifb.resp_valid, ifb.locked} !== 4'b1000) begin
            bad++; $display("FAIL reset_b got=%b exp=1000", {ifb.req_ready, ifb.mem_rd_en, ifb.resp_valid, ifb.locked});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_grant();
        do_req(3'b010, 8'h5A, 1'b1, RC_GRANT, 4'd1);
        do_req(3'b101, 8'h99, 1'b1, RC_GRANT, 4'd3);
    endtask

    task automatic test_bad_id();
        do_req(3'b100, 8'h00, 1'b0, RC_BAD_ID, BAD_SLOT);
        do_req(3'b000, 8'h5A, 1'b0, RC_BAD_ID, BAD_SLOT);
        do_req(3'b111, 8'h11, 1'b0, RC_BAD_ID, BAD_SLOT);
    endtask

    task automatic test_lockout();
        int n;
        bit spur;
        for (int i = 0; i < 3; i++) do_req(3'b001, 8'h22, 1'b0, RC_MISMATCH, 4'd0);
        @(negedge clk);
        total++;
        if (ifa.locked !== 1'b1 || ifa.req_ready !== 1'b0) begin
            bad++; $display("FAIL lock_rise got=%b/%b exp=1/0", ifa.locked, ifa.req_ready);
        end
        drain_lock(n, spur);
        total++;
        if (n !== 16) begin bad++; $display("FAIL lock_len got=%0d exp=16", n); end
        total++;
        if (spur) begin bad++; $display("FAIL lock_quiet got=activity exp=none"); end
        total++;
        if (ifa.req_ready !== 1'b1 || ifa.locked !== 1'b0) begin
            bad++; $display("FAIL lock_exit got=%b/%b exp=1/0", ifa.req_ready, ifa.locked);
        end
    endtask

    task automatic test_grant_clears();
        int n;
        bit spur;
        do_req(3'b110, 8'h01, 1'b0, RC_MISMATCH, 4'd4);
        do_req(3'b110, 8'h02, 1'b0, RC_MISMATCH, 4'd4);
        do_req(3'b110, 8'h3C, 1'b1, RC_GRANT, 4'd4);
        do_req(3'b110, 8'h03, 1'b0, RC_MISMATCH, 4'd4);
        do_req(3'b110, 8'h04, 1'b0, RC_MISMATCH, 4'd4);
        @(negedge clk);
        total++;
        if (ifa.locked !== 1'b0) begin bad++; $display("FAIL no_lock_after_grant got=%b exp=0", ifa.locked); end
        do_req(3'b100, 8'h3C, 1'b0, RC_BAD_ID, BAD_SLOT);
        do_req(3'b110, 8'h05, 1'b0, RC_MISMATCH, 4'd4);
        @(negedge clk);
        total++;
        if (ifa.locked !== 1'b1) begin bad++; $display("FAIL lock_third got=%b exp=1", ifa.locked); end
        drain_lock(n, spur);
        total++;
        if (n !== 16) begin bad++; $display("FAIL lock_len2 got=%0d exp=16", n); end
    endtask

    task automatic test_rd_lat3();
        exp_t e;
        int   c0;
        int   rd_at;
        bit   got;
        logic [7:0] keys [2];
        keys[0] = 8'h5A;
        keys[1] = 8'h5B;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifb.req_valid = 1'b1; ifb.req_id = 3'b010; ifb.req_key = keys[k];
            c0 = cyc;
            e.grant = (k == 0); e.code = (k == 0) ? RC_GRANT : RC_MISMATCH; e.slot = 4'd1; e.cyc = c0 + 7;
            sb.push_back(e);
            rd_at = -1; got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                ifb.req_valid = 1'b0;
                if (ifb.mem_rd_en === 1'b1) rd_at = cyc - c0;
                if (ifb.resp_valid === 1'b1) begin
                    got = 1;
                    e = sb.pop_front();
                    total++;
                    if ({ifb.resp_grant, ifb.resp_code, ifb.resp_slot} !== {e.grant, e.code, e.slot}) begin
                        bad++; $display("FAIL lat3_fields got=%b/%b/%h exp=%b/%b/%h", ifb.resp_grant,
                                        ifb.resp_code, ifb.resp_slot, e.grant, e.code, e.slot);
                    end
                    total++;
                    if (cyc !== e.cyc) begin bad++; $display("FAIL lat3_latency got=%0d exp=7", cyc - c0); end
                end
            end
            total++;
            if (!got) begin bad++; $display("FAIL lat3_timeout got=none exp=resp"); void'(sb.pop_front()); end
            total++;
            if (rd_at !== 2) begin bad++; $display("FAIL lat3_rd_cycle got=%0d exp=2", rd_at); end
        end
    endtask

    task automatic test_reset_wait();
        bit spur;
        @(negedge clk);
        ifa.req_valid = 1'b1; ifa.req_id = 3'b010; ifa.req_key = 8'h5A;
        @(negedge clk);
        ifa.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifa.req_ready !== 1'b0 || ifa.mem_addr !== 4'd1) begin
            bad++; $display("FAIL wait_state got=%b/%h exp=0/1", ifa.req_ready, ifa.mem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ifa.req_ready, ifa.mem_rd_en, ifa.resp_valid, ifa.locked, ifa.mem_addr, ifa.resp_slot, ifa.resp_grant} !== 13'b1000_0000_0000_0) begin
            bad++; $display("FAIL async_reset_wait got=%b/%h/%h exp=1/0/0", ifa.req_ready, ifa.mem_addr, ifa.resp_slot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifa.resp_valid !== 1'b0) spur = 1;
            @(negedge clk);
        end
        total++;
        if (spur) begin bad++; $display("FAIL discarded_resp got=resp exp=none"); end
        do_req(3'b010, 8'h5A, 1'b1, RC_GRANT, 4'd1);
    endtask

    task automatic test_reset_lock();
        int n;
        bit spur;
        for (int i = 0; i < 3; i++) do_req(3'b001, 8'h33, 1'b0, RC_MISMATCH, 4'd0);
        repeat (5) @(negedge clk);
        total++;
        if (ifa.locked !== 1'b1) begin bad++; $display("FAIL pre_reset_lock got=%b exp=1", ifa.locked); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ifa.locked !== 1'b0 || ifa.req_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset_lock got=%b/%b exp=0/1", ifa.locked, ifa.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(3'b001, 8'h11, 1'b1, RC_GRANT, 4'd0);
        do_req(3'b001, 8'h44, 1'b0, RC_MISMATCH, 4'd0);
        do_req(3'b001, 8'h44, 1'b0, RC_MISMATCH, 4'd0);
        @(negedge clk);
        total++;
        if (ifa.locked !== 1'b0) begin bad++; $display("FAIL fail_cnt_cleared got=%b exp=0", ifa.locked); end
        do_req(3'b001, 8'h44, 1'b0, RC_MISMATCH, 4'd0);
        @(negedge clk);
        drain_lock(n, spur);
        total++;
        if (n !== 16) begin bad++; $display("FAIL lock_len3 got=%0d exp=16", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h11; mem[1] = 8'h5A; mem[3] = 8'h99; mem[4] = 8'h3C;
        ifa.req_valid = 1'b0; ifa.req_id = '0; ifa.req_key = '0;
        ifb.req_valid = 1'b0; ifb.req_id = '0; ifb.req_key = '0;
        test_reset();
        test_grant();
        test_bad_id();
        test_lockout();
        test_grant_clears();
        test_rd_lat3();
        test_reset_wait();
        test_reset_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
